// File: rtl/store_buffer.sv
// In-order store buffer: queues byte-masked word stores ahead of memory and
// flags loads that hit a pending store word. No input-to-output bypass.
module store_buffer #(
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_addr,
    input  logic [31:0]   in_data,
    input  logic [3:0]    in_mask,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [29:0]   mem_addr,
    output logic [31:0]   mem_data,
    output logic [3:0]    mem_mask,
    input  logic [31:0]   ld_addr,
    output logic          ld_hazard,
    output logic [CW-1:0] count
);

    logic [29:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [3:0]       r_mask [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_hit;
    logic             w_unused;

    // Byte offsets play no part in word-granular storage or hazard matching.
    assign w_unused = ^{in_addr[1:0], ld_addr[1:0]};

    assign w_full    = (r_count == CW'(DEPTH));
    assign in_ready  = !w_full && !rst;
    assign mem_valid = !rst && (r_count != '0);
    assign count     = rst ? '0 : r_count;

    // A zero-mask store is handshaken but never occupies an entry.
    assign w_push = in_valid && in_ready && (in_mask != 4'b0000);
    assign w_pop  = mem_valid && mem_ready;

    assign mem_addr = r_addr[r_rptr];
    assign mem_data = r_data[r_rptr];
    assign mem_mask = r_mask[r_rptr];

    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        assign w_hit[i] = r_vld[i] && (r_addr[i] == ld_addr[31:2]);
    end
    assign ld_hazard = !rst && (|w_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (w_pop) begin
                r_rptr        <= r_rptr + AW'(1);
                r_vld[r_rptr] <= 1'b0;
            end
            if (w_push) begin
                r_wptr        <= r_wptr + AW'(1);
                r_vld[r_wptr] <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; validity lives in r_vld and r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= in_addr[31:2];
            r_data[r_wptr] <= in_data;
            r_mask[r_wptr] <= in_mask;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a queue model predicts every output each
// cycle; head entries are compared against the queue front as they drain.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_addr;
    logic [31:0]   in_data;
    logic [3:0]    in_mask;
    logic          mem_valid;
    logic          mem_ready;
    logic [29:0]   mem_addr;
    logic [31:0]   mem_data;
    logic [3:0]    mem_mask;
    logic [31:0]   ld_addr;
    logic          ld_hazard;
    logic [CW-1:0] count;

    ent_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .in_mask(in_mask),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_mask(mem_mask),
        .ld_addr(ld_addr), .ld_hazard(ld_hazard), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check outputs against the model, then
    // advance the model to what the coming rising edge must do.
    task automatic step(input logic r, input logic iv, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        input logic mr, input logic [31:0] ld);
        logic e_rdy, e_vld, e_hz;
        @(negedge clk);
        rst = r; in_valid = iv; in_addr = a; in_data = d; in_mask = m;
        mem_ready = mr; ld_addr = ld;
        #1;
        e_rdy = !r && (q.size() < DEPTH);
        e_vld = !r && (q.size() != 0);
        e_hz  = 1'b0;
        if (!r) foreach (q[i]) if (q[i].addr == ld[31:2]) e_hz = 1'b1;
        chk("in_ready",  32'(in_ready),  32'(e_rdy));
        chk("mem_valid", 32'(mem_valid), 32'(e_vld));
        chk("ld_hazard", 32'(ld_hazard), 32'(e_hz));
        chk("count",     32'(count),     r ? 32'd0 : 32'(q.size()));
        if (e_vld) begin
            chk("mem_addr", 32'(mem_addr), 32'(q[0].addr));
            chk("mem_data", mem_data,      q[0].data);
            chk("mem_mask", 32'(mem_mask), 32'(q[0].mask));
        end
        if (r) q.delete();
        else begin
            if (e_vld && mr) void'(q.pop_front());
            if (iv && e_rdy && (m != 4'b0000)) q.push_back('{a[31:2], d, m});
        end
    endtask

    task automatic idle(input logic mr, input logic [31:0] ld);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, mr, ld);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic mr);
        step(1'b0, 1'b1, a, d, m, mr, 32'hFFFF_FFF0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; in_mask = '0;
        mem_ready = 1'b0; ld_addr = '0;

        // Reset held with traffic requested.
        step(1'b1, 1'b1, 32'h104, 32'h1, 4'hF, 1'b1, 32'h104);
        step(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);

        // Single store into empty buffer, then pop.
        push(32'h0000_0104, 32'h0000_AB00, 4'b0010, 1'b0);
        idle(1'b0, 32'h0000_0104);
        chk("single_addr", 32'(mem_addr), 32'h41);
        chk("single_data", mem_data, 32'h0000_AB00);
        idle(1'b1, 32'h0);
        idle(1'b0, 32'h0000_0104);

        // Zero mask is swallowed.
        push(32'h0000_0400, 32'hDEAD_BEEF, 4'b0000, 1'b0);
        idle(1'b0, 32'h0000_0400);

        // Fill under backpressure; fifth push refused; head held stable.
        for (int i = 0; i < 5; i++)
            push(32'h1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 1'b0);
        idle(1'b0, 32'h1010);
        idle(1'b0, 32'h1000);
        for (int i = 0; i < 4; i++) idle(1'b1, 32'h0);
        idle(1'b0, 32'h0);

        // Simultaneous push/pop at count 2, streamed across pointer wrap.
        push(32'h2000, 32'hB000_0000, 4'h1, 1'b0);
        push(32'h2004, 32'hB000_0001, 4'h2, 1'b0);
        for (int i = 2; i < 10; i++)
            push(32'h2000 + 32'(i * 4), 32'hB000_0000 + 32'(i), 4'(i), 1'b1);
        idle(1'b1, 32'h0);
        idle(1'b1, 32'h0);
        idle(1'b0, 32'h2024);

        // Load hazard detection.
        push(32'h0000_0200, 32'h1111_1111, 4'hF, 1'b0);
        push(32'h0000_0310, 32'h2222_2222, 4'hC, 1'b0);
        idle(1'b0, 32'h0000_0203);
        chk("hz_0x203", 32'(ld_hazard), 32'd1);
        idle(1'b0, 32'h0000_0314);
        chk("hz_0x314", 32'(ld_hazard), 32'd0);
        idle(1'b0, 32'h0000_0311);
        idle(1'b1, 32'h0000_0200);
        idle(1'b1, 32'h0000_0310);
        idle(1'b0, 32'h0000_0200);
        idle(1'b0, 32'h0000_0310);

        // Reset mid-operation with push and pop both requested.
        push(32'h3000, 32'hC000_0000, 4'hF, 1'b0);
        push(32'h3004, 32'hC000_0001, 4'hF, 1'b0);
        push(32'h3008, 32'hC000_0002, 4'hF, 1'b0);
        step(1'b1, 1'b1, 32'h300C, 32'hC000_0003, 4'hF, 1'b1, 32'h3000);
        idle(1'b0, 32'h3000);
        push(32'h4000, 32'hD000_0000, 4'h5, 1'b0);
        idle(1'b0, 32'h4000);
        idle(1'b1, 32'h3004);
        idle(1'b0, 32'h3008);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores; power of two, at least 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  store request present.
REQ-005 SHALL have port in_ready  output  1  buffer accepts a store this cycle.
REQ-006 SHALL have port in_addr  input  32  store byte address.
REQ-007 SHALL have port in_data  input  32  store data, already shifted into its byte lanes.
REQ-008 SHALL have port in_mask  input  4  byte-lane write enables; bit i enables byte lane i.
REQ-009 SHALL have port mem_valid  output  1  head entry offered to memory.
REQ-010 SHALL have port mem_ready  input  1  memory takes the head entry.
REQ-011 SHALL have port mem_addr  output  30  word address of head entry (in_addr[31:2]).
REQ-012 SHALL have port mem_data  output  32  head entry data.
REQ-013 SHALL have port mem_mask  output  4  head entry byte mask.
REQ-014 SHALL have port ld_addr  input  32  load byte address for hazard check.
REQ-015 SHALL have port ld_hazard  output  1  pending store to the same word as ld_addr.
REQ-016 SHALL have port count  output  log2(DEPTH)+1  number of valid entries.

Function
REQ-017 SHALL implement an in-order FIFO of DEPTH entries, each holding {addr[31:2], data, mask}.
REQ-018 SHALL assert in_ready = !full && !rst; full when count == DEPTH.
REQ-019 SHALL push on a rising edge when in_valid && in_ready && in_mask != 0.
REQ-020 SHALL treat in_mask == 0 with in_valid && in_ready as accepted and discarded: no entry, count unchanged.
REQ-021 SHALL assert mem_valid = (count != 0); mem_addr/data/mask SHALL be driven combinationally from the head entry.
REQ-022 SHALL pop on a rising edge when mem_valid && mem_ready.
REQ-023 SHALL hold mem_addr, mem_data and mem_mask stable while mem_valid && !mem_ready.
REQ-024 SHALL provide one-cycle latency: a store pushed into an empty buffer is presented with mem_valid high in the next cycle; there is no input-to-output bypass.
REQ-025 SHALL support push and pop on the same edge when 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-026 SHALL not push when full, even if a pop occurs on the same edge, because in_ready is 0.
REQ-027 SHALL wrap the read and write pointers modulo DEPTH without gaps.
REQ-028 SHALL assert ld_hazard combinationally when any valid entry's addr equals ld_addr[31:2]; the head entry being popped this cycle is included.
REQ-029 SHALL keep ld_hazard at 0 when count == 0, regardless of ld_addr.
REQ-030 SHALL never write memory out of order, duplicate a pop, or merge stores.

Reset
REQ-031 SHALL, on a rising edge with rst high, clear count and both pointers, and discard all entries, including any push or pop requested that cycle.
REQ-032 SHALL drive mem_valid=0, ld_hazard=0, count=0 and in_ready=0 while rst is high; in_ready SHALL be 1 on the first cycle after rst falls.
REQ-033 SHALL not require entry data or address storage to be reset; mem_data/addr/mask are don't-care while mem_valid=0.

Verification
REQ-034 SHALL cover single store: push addr=0x104, data=0x0000AB00, mask=0010 into empty -> next cycle mem_valid=1, mem_addr=0x41, mem_data=0x0000AB00, mem_mask=0010; pop with mem_ready=1 -> count=0.
REQ-035 SHALL cover fill/backpressure: DEPTH=4, mem_ready=0, push 5 stores -> count=4, in_ready=0 after the 4th; 5th not accepted; head held stable; release mem_ready -> 4 pops in push order.
REQ-036 SHALL cover simultaneous push/pop at count=2 -> count stays 2; 8 stores streamed with continuous push/pop -> pointers wrap and output order matches input order.
REQ-037 SHALL cover hazard: entries at 0x200 and 0x310; ld_addr=0x203 -> ld_hazard=1; ld_addr=0x314 -> 0; after both pop -> 0 for all addresses.
REQ-038 SHALL cover zero mask: push mask=0000 into empty -> count stays 0, mem_valid stays 0.
REQ-039 SHALL cover reset mid-operation: count=3 with push and pop both requested, rst=1 for one edge -> count=0, mem_valid=0; next cycle in_ready=1 and no stale entry appears.
